// File: rtl/atmo_light_if.sv
// ---------------------------------------------------------------------------
// atmo_light_if
// Groups the pixel-stream inputs and the atmospheric-light outputs of
// atmo_light_ctrl.
//   pix_valid    : qualifies sof, eof, picture_data and dark_ch_data
//   sof / eof    : first / last pixel of a frame (meaningful only with pix_valid)
//   picture_data : RGB888, [23:16]=R, [15:8]=G, [7:0]=B
//   dark_ch_data : dark-channel value co-timed with picture_data
//   A            : published atmospheric light, holds between updates
//   a_valid      : one-cycle pulse when A is updated
//   busy         : high while a frame is accumulated or finalised
//   frame_err    : one-cycle pulse on a length mismatch or aborted frame
// Handshake: no back-pressure. Each cycle with pix_valid=1 is one beat and is
// consumed on that clock edge; cycles with pix_valid=0 carry nothing.
// master = pixel source, slave = atmo_light_ctrl.
// ---------------------------------------------------------------------------
interface atmo_light_if;
    logic        pix_valid;
    logic        sof;
    logic        eof;
    logic [23:0] picture_data;
    logic [7:0]  dark_ch_data;
    logic [7:0]  A;
    logic        a_valid;
    logic        busy;
    logic        frame_err;

    modport master (
        output pix_valid, sof, eof, picture_data, dark_ch_data,
        input  A, a_valid, busy, frame_err
    );

    modport slave (
        input  pix_valid, sof, eof, picture_data, dark_ch_data,
        output A, a_valid, busy, frame_err
    );
endinterface

// File: rtl/atmo_light_ctrl.sv
// ---------------------------------------------------------------------------
// atmo_light_ctrl
// Frame-level atmospheric-light (A) estimator for the dark-channel dehaze
// path. Across one frame it tracks the pixel with the largest dark-channel
// value (first in raster order wins on ties), keeps max(R,G,B) of that pixel,
// and at frame end clamps it to [A_MIN, A_MAX] and publishes it as A if the
// frame held exactly H_PIXEL*V_PIXEL beats.
// Ports:
//   sys_clk    : clock, rising edge
//   sys_rst_n  : synchronous active-low reset
//   bus        : atmo_light_if.slave (pixel stream in, A/status out)
//   dbg_state  : current FSM state (0=IDLE, 1=RUN, 2=FINAL)
// ---------------------------------------------------------------------------
module atmo_light_ctrl #(
    parameter int         H_PIXEL = 640,
    parameter int         V_PIXEL = 480,
    parameter logic [7:0] A_INIT  = 8'd220,
    parameter logic [7:0] A_MIN   = 8'd100,
    parameter logic [7:0] A_MAX   = 8'd235
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    atmo_light_if.slave   bus,
    output logic [1:0]    dbg_state
);

    // One extra bit beyond the frame size so over-long frames stay distinct
    // from a correct count before the counter saturates.
    localparam int              CNT_W     = $clog2(H_PIXEL * V_PIXEL + 1) + 1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(H_PIXEL * V_PIXEL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]       best_dark_q, best_dark_d;
    logic [7:0]       best_rgb_q, best_rgb_d;
    logic [7:0]       a_q, a_d;
    logic             a_valid_q, a_valid_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;

    logic [7:0] pix_r, pix_g, pix_b;
    logic [7:0] rgb_max;

    function automatic logic [7:0] clamp_a(input logic [7:0] v);
        if (v < A_MIN) begin
            return A_MIN;
        end else if (v > A_MAX) begin
            return A_MAX;
        end
        return v;
    endfunction

    always_comb begin
        pix_r   = bus.picture_data[23:16];
        pix_g   = bus.picture_data[15:8];
        pix_b   = bus.picture_data[7:0];
        rgb_max = pix_r;
        if (pix_g > rgb_max) rgb_max = pix_g;
        if (pix_b > rgb_max) rgb_max = pix_b;
    end

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        best_dark_d = best_dark_q;
        best_rgb_d  = best_rgb_q;
        a_d         = a_q;
        a_valid_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.pix_valid && bus.sof) begin
                    pix_cnt_d   = CNT_W'(1);
                    best_dark_d = bus.dark_ch_data;
                    best_rgb_d  = rgb_max;
                    state_d     = bus.eof ? FINAL : RUN;
                end
            end
            RUN: begin
                if (bus.pix_valid) begin
                    if (bus.sof) begin
                        // Unexpected new frame: flag the abort and restart
                        // with this beat as pixel 1.
                        frame_err_d = 1'b1;
                        pix_cnt_d   = CNT_W'(1);
                        best_dark_d = bus.dark_ch_data;
                        best_rgb_d  = rgb_max;
                    end else begin
                        if (pix_cnt_q != '1) begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                        // Strict compare keeps the earliest pixel on ties.
                        if (bus.dark_ch_data > best_dark_q) begin
                            best_dark_d = bus.dark_ch_data;
                            best_rgb_d  = rgb_max;
                        end
                    end
                    if (bus.eof) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                if (pix_cnt_q == FRAME_CNT) begin
                    a_d       = clamp_a(best_rgb_q);
                    a_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            pix_cnt_q   <= '0;
            best_dark_q <= '0;
            best_rgb_q  <= '0;
            a_q         <= A_INIT;
            a_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            best_dark_q <= best_dark_d;
            best_rgb_q  <= best_rgb_d;
            a_q         <= a_d;
            a_valid_q   <= a_valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.A         = a_q;
    assign bus.a_valid   = a_valid_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_atmo_light_ctrl.sv
// Bench for atmo_light_ctrl with a 4x2 frame. Inputs are driven and outputs
// sampled on the falling edge; a monitor counts output pulses each cycle.
module tb_atmo_light_ctrl;

  localparam int FRAME = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [1:0] dbg_state;

  always #5 sys_clk = ~sys_clk;

  atmo_light_if bus ();

  atmo_light_ctrl #(
    .H_PIXEL(4),
    .V_PIXEL(2),
    .A_INIT (8'd220),
    .A_MIN  (8'd100),
    .A_MAX  (8'd235)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int av_cnt = 0;
  int fe_cnt = 0;

  logic [23:0] fr_rgb[16];
  logic [7:0]  fr_dark[16];
  logic [7:0]  a_model = 8'd220;

  // Pulse counters, sampled mid-cycle after outputs have settled.
  always @(posedge sys_clk) begin
    #2;
    if (bus.a_valid === 1'b1) av_cnt++;
    if (bus.frame_err === 1'b1) fe_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] clamp_ref(input logic [7:0] v);
    if (v < 8'd100) return 8'd100;
    if (v > 8'd235) return 8'd235;
    return v;
  endfunction

  // A expected from the frame held in fr_* (length n): brightest dark pixel,
  // first occurrence wins, max of its channels, clamped.
  function automatic logic [7:0] frame_a(input int n);
    int          best;
    logic [7:0]  m;
    logic [23:0] px;
    best = 0;
    for (int i = 1; i < n; i++)
      if (fr_dark[i] > fr_dark[best]) best = i;
    px = fr_rgb[best];
    m  = px[23:16];
    if (px[15:8] > m) m = px[15:8];
    if (px[7:0] > m) m = px[7:0];
    return clamp_ref(m);
  endfunction

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.eof       = 1'b0;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic beat(input logic s, input logic e, input logic [23:0] rgb,
                      input logic [7:0] dark);
    bus.pix_valid    = 1'b1;
    bus.sof          = s;
    bus.eof          = e;
    bus.picture_data = rgb;
    bus.dark_ch_data = dark;
    @(negedge sys_clk);
  endtask

  task automatic send_frame(input int n, input bit gaps, input int gap_at);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at || (gaps && $urandom_range(0, 3) == 0)) idle(1);
      beat(i == 0, i == n - 1, fr_rgb[i], fr_dark[i]);
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic fill_bg();
    for (int i = 0; i < 16; i++) begin
      fr_dark[i] = 8'd10;
      fr_rgb[i]  = 24'h202020;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sys_rst_n = 1'b0;
    idle(2);
    sys_rst_n = 1'b1;
    idle(1);
    checks++;
    if (bus.A !== 8'd220) begin errors++; $display("FAIL reset_A got %0d exp 220", bus.A); end
    checks++;
    if (bus.a_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got av=%b fe=%b busy=%b exp 0 0 0", bus.a_valid, bus.frame_err, bus.busy);
    end
    for (int i = 0; i < 3; i++) beat(1'b0, i == 2, 24'h0a0b0c, 8'd77);
    idle(2);
    checks++;
    if (bus.busy !== 1'b0 || av_cnt != 0 || fe_cnt != 0) begin
      errors++;
      $display("FAIL idle_no_sof got busy=%b av=%0d fe=%0d exp 0 0 0", bus.busy, av_cnt, fe_cnt);
    end
  endtask

  task automatic test_full_frame();
    int av0, fe0;
    fill_bg();
    fr_dark[5] = 8'd90;
    fr_rgb[5]  = {8'd30, 8'd200, 8'd50};
    av0 = av_cnt; fe0 = fe_cnt;
    send_frame(FRAME, 1'b0, 3);
    checks++;
    if (bus.a_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL full_final got av=%b busy=%b exp 0 1", bus.a_valid, bus.busy);
    end
    idle(1);
    checks++;
    if (bus.a_valid !== 1'b1 || bus.A !== 8'd200) begin
      errors++; $display("FAIL full_pulse got av=%b A=%0d exp 1 200", bus.a_valid, bus.A);
    end
    idle(1);
    checks++;
    if (bus.a_valid !== 1'b0 || bus.busy !== 1'b0 || bus.A !== 8'd200 ||
        av_cnt - av0 != 1 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL full_after got av=%b busy=%b A=%0d pulses=%0d errs=%0d exp 0 0 200 1 0",
               bus.a_valid, bus.busy, bus.A, av_cnt - av0, fe_cnt - fe0);
    end
    a_model = 8'd200;
  endtask

  task automatic test_tie_clamp();
    fill_bg();
    fr_dark[2] = 8'd50; fr_rgb[2] = {8'd250, 8'd0, 8'd0};
    fr_dark[6] = 8'd50; fr_rgb[6] = {8'd120, 8'd0, 8'd0};
    send_frame(FRAME, 1'b0, -1);
    idle(1);
    checks++;
    if (bus.a_valid !== 1'b1 || bus.A !== 8'd235) begin
      errors++; $display("FAIL tie_clamp_hi got av=%b A=%0d exp 1 235", bus.a_valid, bus.A);
    end
    idle(2);
    fill_bg();
    fr_dark[4] = 8'd60; fr_rgb[4] = {8'd40, 8'd10, 8'd5};
    send_frame(FRAME, 1'b0, -1);
    idle(1);
    checks++;
    if (bus.a_valid !== 1'b1 || bus.A !== 8'd100) begin
      errors++; $display("FAIL clamp_lo got av=%b A=%0d exp 1 100", bus.a_valid, bus.A);
    end
    idle(2);
    a_model = 8'd100;
  endtask

  task automatic test_short_frame();
    int av0, fe0;
    fill_bg();
    fr_dark[1] = 8'd99; fr_rgb[1] = {8'd180, 8'd0, 8'd0};
    av0 = av_cnt; fe0 = fe_cnt;
    send_frame(7, 1'b0, -1);
    idle(1);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.a_valid !== 1'b0 || bus.A !== a_model) begin
      errors++;
      $display("FAIL short_err got fe=%b av=%b A=%0d exp 1 0 %0d", bus.frame_err, bus.a_valid, bus.A, a_model);
    end
    idle(2);
    checks++;
    if (av_cnt != av0 || fe_cnt - fe0 != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL short_counts got av=%0d fe=%0d busy=%b exp 0 1 0", av_cnt - av0, fe_cnt - fe0, bus.busy);
    end
  endtask

  task automatic test_mid_sof();
    int av0, fe0;
    logic [7:0] exp_a;
    av0 = av_cnt; fe0 = fe_cnt;
    // Aborted frame carries a dominant pixel that must not leak through.
    beat(1'b1, 1'b0, {8'd230, 8'd0, 8'd0}, 8'd200);
    beat(1'b0, 1'b0, 24'h111111, 8'd5);
    beat(1'b0, 1'b0, 24'h222222, 8'd6);
    for (int i = 0; i < FRAME; i++) begin
      fr_dark[i] = 8'($urandom_range(0, 40));
      fr_rgb[i]  = 24'($urandom_range(0, 24'hffffff));
    end
    exp_a = frame_a(FRAME);
    for (int i = 0; i < FRAME; i++) begin
      beat(i == 0, i == FRAME - 1, fr_rgb[i], fr_dark[i]);
      if (i == 0) begin
        checks++;
        if (bus.frame_err !== 1'b1) begin
          errors++; $display("FAIL mid_sof_err got %b exp 1", bus.frame_err);
        end
      end
    end
    idle(1);
    checks++;
    if (bus.a_valid !== 1'b1 || bus.A !== exp_a) begin
      errors++; $display("FAIL mid_sof_a got av=%b A=%0d exp 1 %0d", bus.a_valid, bus.A, exp_a);
    end
    idle(2);
    checks++;
    if (av_cnt - av0 != 1 || fe_cnt - fe0 != 1) begin
      errors++; $display("FAIL mid_sof_counts got av=%0d fe=%0d exp 1 1", av_cnt - av0, fe_cnt - fe0);
    end
    a_model = exp_a;
  endtask

  task automatic test_reset_mid();
    int av0, fe0;
    av0 = av_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) beat(i == 0, 1'b0, 24'h404040, 8'(i));
    sys_rst_n = 1'b0;
    idle(1);
    sys_rst_n = 1'b1;
    idle(2);
    a_model = 8'd220;
    checks++;
    if (bus.A !== 8'd220 || bus.busy !== 1'b0 || av_cnt != av0 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL reset_mid got A=%0d busy=%b av=%0d fe=%0d exp 220 0 0 0",
               bus.A, bus.busy, av_cnt - av0, fe_cnt - fe0);
    end
    fill_bg();
    fr_dark[7] = 8'd33; fr_rgb[7] = {8'd1, 8'd2, 8'd150};
    send_frame(FRAME, 1'b1, -1);
    idle(1);
    checks++;
    if (bus.a_valid !== 1'b1 || bus.A !== 8'd150) begin
      errors++; $display("FAIL reset_mid_frame got av=%b A=%0d exp 1 150", bus.a_valid, bus.A);
    end
    idle(2);
    a_model = 8'd150;
  endtask

  task automatic test_random();
    int n, av0, fe0;
    bit good;
    logic [7:0] exp_a;
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(6, 10);
      for (int i = 0; i < n; i++) begin
        fr_dark[i] = 8'($urandom_range(0, 15));
        fr_rgb[i]  = 24'($urandom_range(0, 24'hffffff));
      end
      good  = (n == FRAME);
      exp_a = good ? frame_a(n) : a_model;
      av0 = av_cnt; fe0 = fe_cnt;
      send_frame(n, 1'b1, -1);
      idle(1);
      checks++;
      if (bus.a_valid !== good || bus.frame_err !== !good || bus.A !== exp_a) begin
        errors++;
        $display("FAIL rand_frame%0d len=%0d got av=%b fe=%b A=%0d exp %b %b %0d",
                 f, n, bus.a_valid, bus.frame_err, bus.A, good, !good, exp_a);
      end
      idle($urandom_range(1, 3));
      checks++;
      if (av_cnt - av0 != int'(good) || fe_cnt - fe0 != int'(!good) || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_counts%0d got av=%0d fe=%0d busy=%b exp %0d %0d 0",
                 f, av_cnt - av0, fe_cnt - fe0, bus.busy, good, !good);
      end
      a_model = exp_a;
    end
  endtask

  initial begin
    sys_rst_n        = 1'b0;
    bus.pix_valid    = 1'b0;
    bus.sof          = 1'b0;
    bus.eof          = 1'b0;
    bus.picture_data = '0;
    bus.dark_ch_data = '0;
    @(negedge sys_clk);
    test_reset();
    test_full_frame();
    test_tie_clamp();
    test_short_frame();
    test_mid_sof();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
